// File: rtl/vslc_pkg.sv
// Shared definitions for the Very Simple Logic Controller (VSLC).
// Purpose : opcode encoding, stack geometry and instruction field
//           positions, plus small stack helper functions.
// Ports   : none (package).
// Option  : VSLC_EDGE_EN enables the rising-edge load (LDR) in the core.
package vslc_pkg;

    localparam int STACK_DEPTH = 16;
    localparam int OPC_MSB     = 7;
    localparam int OPC_LSB     = 4;
    localparam int ARG_W       = 3;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LD   = 4'h1,
        OP_LDO  = 4'h2,
        OP_ST   = 4'h3,
        OP_SET  = 4'h4,
        OP_RST  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NOT  = 4'h9,
        OP_DUP  = 4'hA,
        OP_DROP = 4'hB,
        OP_SWAP = 4'hC,
        OP_PUSH = 4'hD,
        OP_LDR  = 4'hE,
        OP_CLR  = 4'hF
    } opcode_e;

    // Push v on top; the deepest entry falls off silently.
    function automatic logic [STACK_DEPTH-1:0] stk_push(
        input logic [STACK_DEPTH-1:0] s,
        input logic                   v
    );
        return {s[STACK_DEPTH-2:0], v};
    endfunction

    // Pop the top entry; zeros shift in from the bottom.
    function automatic logic [STACK_DEPTH-1:0] stk_pop(
        input logic [STACK_DEPTH-1:0] s
    );
        return {1'b0, s[STACK_DEPTH-1:1]};
    endfunction

endpackage

// File: rtl/vslc_if.sv
// Pin bundle of the VSLC Tiny Tapeout project.
// Purpose : groups enable, instruction, field inputs and output pins.
// Signals : ena, ui_in[7:0] (instruction), uio_in[7:0] (field inputs X),
//           uo_out[7:0] (coils Y), uio_out[7:0], uio_oe[7:0] (tied 0).
// Modports: master (drives instruction side), slave (the controller).
interface vslc_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/vslc_core.sv
// VSLC core.
// Purpose : splits the instruction byte into fields, keeps the optional
//           edge register P and instantiates the execution unit as exec.
// Ports   : clk, rst_n (async active-low), ena, ui_in (instruction),
//           uio_in (field inputs X), uo_out (registered coils Y).
// Option  : VSLC_EDGE_EN adds P (previous X) for rising-edge loads.
module vslc_core
    import vslc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out
);

    opcode_e          opcode_s;
    logic [ARG_W-1:0] arg_s;
    logic [7:0]       rise_s;
    logic             unused_ui_s;

    assign opcode_s    = opcode_e'(ui_in[OPC_MSB:OPC_LSB]);
    assign arg_s       = ui_in[ARG_W-1:0];
    assign unused_ui_s = ui_in[3];

`ifdef VSLC_EDGE_EN
    logic [7:0] p_r;

    // Previous-X register; like all other state it holds on NOP or ena=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r <= 8'h00;
        end else if (ena && (opcode_s != OP_NOP)) begin
            p_r <= uio_in;
        end else begin
            p_r <= p_r;
        end
    end

    assign rise_s = uio_in & ~p_r;
`else
    assign rise_s = 8'h00;
`endif

    vslc_exec exec (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .opcode (opcode_s),
        .arg    (arg_s),
        .x      (uio_in),
        .rise_x (rise_s),
        .y      (uo_out)
    );

endmodule

// File: rtl/vslc_exec.sv
// VSLC execution unit.
// Purpose : holds the 16-deep 1-bit stack, decodes one instruction per
//           enabled clock and updates the latched coil register.
// Ports   : clk, rst_n (async active-low), ena, opcode, arg (bit index a),
//           x (field inputs), rise_x (X & ~P, used only with VSLC_EDGE_EN),
//           y (registered coils).
// Option  : VSLC_EDGE_EN -- opcode LDR pushes rise_x[a]; otherwise NOP.
module vslc_exec
    import vslc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  opcode_e          opcode,
    input  logic [ARG_W-1:0] arg,
    input  logic [7:0]       x,
    input  logic [7:0]       rise_x,
    output logic [7:0]       y
);

    logic [STACK_DEPTH-1:0] stack;
    logic [STACK_DEPTH-1:0] stack_nxt_s;
    logic [7:0]             y_r;
    logic [7:0]             y_nxt_s;
    logic                   tos;
    logic                   nos;
    logic                   hos;

    assign tos = stack[0];
    assign nos = stack[1];
    assign hos = stack[2];
    assign y   = y_r;

`ifndef VSLC_EDGE_EN
    logic unused_rise_s;
    assign unused_rise_s = |rise_x;
`endif

    // Instruction decode: next stack and next coil values.
    always_comb begin
        stack_nxt_s = stack;
        y_nxt_s     = y_r;
        case (opcode)
            OP_NOP:  stack_nxt_s = stack;
            OP_LD:   stack_nxt_s = stk_push(stack, x[arg]);
            // Y is registered, so an LDO right after an ST sees the new bit.
            OP_LDO:  stack_nxt_s = stk_push(stack, y_r[arg]);
            OP_ST:   y_nxt_s[arg] = tos;
            OP_SET: begin
                if (tos) begin
                    y_nxt_s[arg] = 1'b1;
                end else begin
                    y_nxt_s[arg] = y_r[arg];
                end
            end
            OP_RST: begin
                if (tos) begin
                    y_nxt_s[arg] = 1'b0;
                end else begin
                    y_nxt_s[arg] = y_r[arg];
                end
            end
            // Binary ops consume tos and nos, leaving the result on top.
            OP_AND:  stack_nxt_s = {1'b0, stack[STACK_DEPTH-1:3], hos, tos & nos};
            OP_OR:   stack_nxt_s = {1'b0, stack[STACK_DEPTH-1:3], hos, tos | nos};
            OP_XOR:  stack_nxt_s = {1'b0, stack[STACK_DEPTH-1:3], hos, tos ^ nos};
            OP_NOT:  stack_nxt_s = {stack[STACK_DEPTH-1:1], ~tos};
            OP_DUP:  stack_nxt_s = stk_push(stack, tos);
            OP_DROP: stack_nxt_s = stk_pop(stack);
            OP_SWAP: stack_nxt_s = {stack[STACK_DEPTH-1:2], tos, nos};
            OP_PUSH: stack_nxt_s = stk_push(stack, arg[0]);
`ifdef VSLC_EDGE_EN
            OP_LDR:  stack_nxt_s = stk_push(stack, rise_x[arg]);
`else
            OP_LDR:  stack_nxt_s = stack;
`endif
            OP_CLR:  stack_nxt_s = {STACK_DEPTH{1'b0}};
            default: begin
                stack_nxt_s = stack;
                y_nxt_s     = y_r;
            end
        endcase
    end

    // Stack and coil registers; hold whenever ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack <= {STACK_DEPTH{1'b0}};
            y_r   <= 8'h00;
        end else if (ena) begin
            stack <= stack_nxt_s;
            y_r   <= y_nxt_s;
        end else begin
            stack <= stack;
            y_r   <= y_r;
        end
    end

endmodule

// File: rtl/jimktrains_vslc.sv
// Tiny Tapeout wrapper for the Very Simple Logic Controller.
// Purpose : ties the bidirectional pins to permanent inputs and hosts the
//           core as instance core.
// Ports   : clk, rst_n (async active-low), bus (vslc_if.slave: ena, ui_in,
//           uio_in, uo_out, uio_out, uio_oe).
// Option  : VSLC_EDGE_EN enables the rising-edge load instruction.
module jimktrains_vslc (
    input  logic    clk,
    input  logic    rst_n,
    vslc_if.slave   bus
);

    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    vslc_core core (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (bus.ena),
        .ui_in  (bus.ui_in),
        .uio_in (bus.uio_in),
        .uo_out (bus.uo_out)
    );

endmodule

// File: tb/tb_jimktrains_vslc.sv
// Self-checking bench for jimktrains_vslc against a queue-based stack model.
module tb_jimktrains_vslc;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model: ms[0] is top of stack, always 16 entries.
    bit       ms[$];
    bit [7:0] my;
    bit [7:0] mp;

    vslc_if bus();

    jimktrains_vslc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        ms.delete();
        for (int i = 0; i < 16; i++) ms.push_back(1'b0);
        my = 8'h00;
        mp = 8'h00;
    endfunction

    function automatic void mpush(bit v);
        ms.push_front(v);
        void'(ms.pop_back());
    endfunction

    function automatic bit mpop();
        bit v;
        v = ms.pop_front();
        ms.push_back(1'b0);
        return v;
    endfunction

    function automatic logic [15:0] mstack();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = ms[i];
        return r;
    endfunction

    function automatic void model_apply(logic [7:0] ins, logic [7:0] x, logic en);
        logic [3:0] op;
        logic [2:0] a;
        bit t;
        bit n;
        op = ins[7:4];
        a  = ins[2:0];
        if (!en) return;
        case (op)
            4'h1: mpush(x[a]);
            4'h2: mpush(my[a]);
            4'h3: my[a] = ms[0];
            4'h4: if (ms[0]) my[a] = 1'b1;
            4'h5: if (ms[0]) my[a] = 1'b0;
            4'h6: begin t = mpop(); n = mpop(); mpush(t & n); end
            4'h7: begin t = mpop(); n = mpop(); mpush(t | n); end
            4'h8: begin t = mpop(); n = mpop(); mpush(t ^ n); end
            4'h9: begin t = mpop(); mpush(~t); end
            4'hA: mpush(ms[0]);
            4'hB: void'(mpop());
            4'hC: begin t = mpop(); n = mpop(); mpush(t); mpush(n); end
            4'hD: mpush(ins[0]);
`ifdef VSLC_EDGE_EN
            4'hE: mpush(x[a] & ~mp[a]);
`endif
            4'hF: for (int i = 0; i < 16; i++) ms[i] = 1'b0;
            default: ;
        endcase
`ifdef VSLC_EDGE_EN
        if (op != 4'h0) mp = x;
`endif
    endfunction

    // Present one instruction for one clock and advance the model.
    task automatic issue(input logic [7:0] ins, input logic [7:0] x, input logic en);
        @(negedge clk);
        bus.ena    = en;
        bus.ui_in  = ins;
        bus.uio_in = x;
        @(posedge clk);
        model_apply(ins, x, en);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) issue(8'h00, 8'hA5, 1'b1);
        checks++;
        if (bus.uo_out !== 8'h00) begin
            errors++; $display("FAIL reset_uo_out got %h want 00", bus.uo_out);
        end
        checks++;
        if (dut.core.exec.stack !== 16'h0000) begin
            errors++; $display("FAIL reset_stack got %h want 0000", dut.core.exec.stack);
        end
        checks++;
        if ({bus.uio_out, bus.uio_oe} !== 16'h0000) begin
            errors++; $display("FAIL reset_uio got %h want 0000", {bus.uio_out, bus.uio_oe});
        end
    endtask

    task automatic test_load_store();
        issue(8'h10, 8'h05, 1'b1);  // LD 0
        issue(8'h11, 8'h05, 1'b1);  // LD 1
        issue(8'h70, 8'h05, 1'b1);  // OR
        issue(8'h37, 8'h05, 1'b1);  // ST 7
        checks++;
        if (dut.core.exec.stack[0] !== 1'b1) begin
            errors++; $display("FAIL ld_st_tos got %b want 1", dut.core.exec.stack[0]);
        end
        checks++;
        if (bus.uo_out !== 8'h80) begin
            errors++; $display("FAIL ld_st_uo_out got %h want 80", bus.uo_out);
        end
        issue(8'h27, 8'h00, 1'b1);  // LDO 7 right after the store
        checks++;
        if (dut.core.exec.stack[0] !== 1'b1) begin
            errors++; $display("FAIL ldo_after_st got %b want 1", dut.core.exec.stack[0]);
        end
    endtask

    task automatic test_stack_ops();
        logic [7:0] prog [7];
        prog = '{8'hF0, 8'hD1, 8'hD0, 8'hC0, 8'hA0, 8'h80, 8'hB0};
        for (int i = 0; i < 7; i++) begin
            issue(prog[i], 8'h00, 1'b1);
            checks++;
            if (dut.core.exec.stack !== mstack()) begin
                errors++;
                $display("FAIL stack_op%0d got %h want %h", i, dut.core.exec.stack, mstack());
            end
        end
        issue(8'h90, 8'h00, 1'b1);  // NOT
        checks++;
        if (dut.core.exec.stack !== mstack()) begin
            errors++; $display("FAIL stack_not got %h want %h", dut.core.exec.stack, mstack());
        end
    endtask

    task automatic test_latch();
        issue(8'hD1, 8'h00, 1'b1);  // PUSH 1
        issue(8'h43, 8'h00, 1'b1);  // SET 3
        checks++;
        if (bus.uo_out[3] !== 1'b1 || bus.uo_out !== my) begin
            errors++; $display("FAIL latch_set got %h want %h", bus.uo_out, my);
        end
        issue(8'hD0, 8'h00, 1'b1);  // PUSH 0
        issue(8'h43, 8'h00, 1'b1);  // SET 3 with tos=0 must hold
        issue(8'h33, 8'h00, 1'b1);  // ST 3
        checks++;
        if (bus.uo_out[3] !== 1'b0 || bus.uo_out !== my) begin
            errors++; $display("FAIL latch_st0 got %h want %h", bus.uo_out, my);
        end
        issue(8'hD1, 8'h00, 1'b1);
        issue(8'h43, 8'h00, 1'b1);
        issue(8'h53, 8'h00, 1'b1);  // RST 3
        checks++;
        if (bus.uo_out[3] !== 1'b0 || bus.uo_out !== my) begin
            errors++; $display("FAIL latch_rst got %h want %h", bus.uo_out, my);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) issue(8'hD1, 8'h00, 1'b1);
        checks++;
        if (dut.core.exec.stack !== 16'hFFFF) begin
            errors++; $display("FAIL overflow got %h want ffff", dut.core.exec.stack);
        end
        for (int i = 0; i < 17; i++) issue(8'hB0, 8'h00, 1'b1);
        checks++;
        if (dut.core.exec.stack !== 16'h0000) begin
            errors++; $display("FAIL underflow got %h want 0000", dut.core.exec.stack);
        end
        issue(8'h60, 8'h00, 1'b1);  // AND on empty stack
        checks++;
        if (dut.core.exec.stack[0] !== 1'b0) begin
            errors++; $display("FAIL empty_and got %b want 0", dut.core.exec.stack[0]);
        end
    endtask

    task automatic test_enable();
        logic [15:0] s_before;
        logic [7:0]  y_before;
        issue(8'hD1, 8'h00, 1'b1);
        issue(8'h31, 8'h00, 1'b1);  // ST 1
        s_before = mstack();
        y_before = my;
        issue(8'hF0, 8'h00, 1'b0);  // CLR while disabled
        issue(8'h51, 8'h00, 1'b0);  // RST 1 while disabled
        checks++;
        if (dut.core.exec.stack !== s_before || bus.uo_out !== y_before) begin
            errors++;
            $display("FAIL ena_hold got %h/%h want %h/%h",
                     dut.core.exec.stack, bus.uo_out, s_before, y_before);
        end
    endtask

    task automatic test_async_reset();
        issue(8'hD1, 8'h00, 1'b1);
        issue(8'h35, 8'h00, 1'b1);  // ST 5
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00 || dut.core.exec.stack !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got %h/%h want 00/0000", bus.uo_out, dut.core.exec.stack);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'hD1, 8'h00, 1'b1);  // first instruction after release
        checks++;
        if (dut.core.exec.stack !== 16'h0001) begin
            errors++; $display("FAIL post_reset got %h want 0001", dut.core.exec.stack);
        end
    endtask

`ifdef VSLC_EDGE_EN
    task automatic test_edge();
        issue(8'hD0, 8'h00, 1'b1);  // X[2]=0 sampled into P
        issue(8'hE2, 8'h04, 1'b1);  // LDR 2 on the rising step
        checks++;
        if (dut.core.exec.stack[0] !== 1'b1) begin
            errors++; $display("FAIL ldr_rise got %b want 1", dut.core.exec.stack[0]);
        end
        issue(8'hE2, 8'h04, 1'b1);  // X[2] stays high
        checks++;
        if (dut.core.exec.stack[0] !== 1'b0) begin
            errors++; $display("FAIL ldr_level got %b want 0", dut.core.exec.stack[0]);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] ins;
        logic [7:0] x;
        logic       en;
        for (int i = 0; i < 400; i++) begin
            ins = 8'($urandom);
            x   = 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            issue(ins, x, en);
            checks++;
            if (dut.core.exec.stack !== mstack() || bus.uo_out !== my) begin
                errors++;
                $display("FAIL random%0d ins %h got %h/%h want %h/%h", i, ins,
                         dut.core.exec.stack, bus.uo_out, mstack(), my);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_store();
        test_stack_ops();
        test_latch();
        test_overflow();
        test_enable();
        test_async_reset();
`ifdef VSLC_EDGE_EN
        test_edge();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
